// File: rtl/perspective_divider.sv
// perspective_divider: divides a clip-space vertex's x, y, z by w through an external
// fixed-point divider and emits the NDC vertex, short-circuiting w==0.
module perspective_divider #(
    parameter int FIXED_WIDTH = 32,
    parameter int COMPONENTS  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vertex_s_valid,
    output logic                       vertex_s_ready,
    input  logic [4*FIXED_WIDTH-1:0]   vertex_s_data,
    output logic                       dividend_m_valid,
    input  logic                       dividend_m_ready,
    output logic [FIXED_WIDTH-1:0]     dividend_m_data,
    output logic                       divisor_m_valid,
    input  logic                       divisor_m_ready,
    output logic [FIXED_WIDTH-1:0]     divisor_m_data,
    input  logic                       quotient_s_valid,
    output logic                       quotient_s_ready,
    input  logic [FIXED_WIDTH-1:0]     quotient_s_data,
    output logic                       ndc_m_valid,
    input  logic                       ndc_m_ready,
    output logic [3*FIXED_WIDTH-1:0]   ndc_m_data,
    output logic                       ndc_m_div_zero,
    output logic                       busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] OUTPUT = 2'd2;
    localparam logic [1:0] LAST   = 2'(COMPONENTS);

    logic [1:0] state;
    logic [1:0] issue_idx;
    logic [1:0] recv_cnt;
    logic       dividend_sent;
    logic       divisor_sent;
    logic [FIXED_WIDTH-1:0] x, y, z, w, r0, r1;
    logic vertex_fire, dividend_fire, divisor_fire, quotient_fire, issue_done;

    assign vertex_s_ready   = state == IDLE && !reset;
    assign busy             = state != IDLE;
    assign dividend_m_valid = state == RUN && issue_idx != LAST && !dividend_sent;
    assign divisor_m_valid  = state == RUN && issue_idx != LAST && !divisor_sent;
    assign dividend_m_data  = issue_idx == 2'd0 ? x : issue_idx == 2'd1 ? y : z;
    assign divisor_m_data   = w;
    // Only accept quotients for divisions that have fully issued
    assign quotient_s_ready = state == RUN && recv_cnt < issue_idx;
    assign ndc_m_valid      = state == OUTPUT;

    assign vertex_fire   = vertex_s_valid && vertex_s_ready;
    assign dividend_fire = dividend_m_valid && dividend_m_ready;
    assign divisor_fire  = divisor_m_valid && divisor_m_ready;
    assign quotient_fire = quotient_s_valid && quotient_s_ready;
    assign issue_done    = (dividend_sent || dividend_fire) && (divisor_sent || divisor_fire);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            issue_idx      <= 2'd0;
            recv_cnt       <= 2'd0;
            dividend_sent  <= 1'b0;
            divisor_sent   <= 1'b0;
            x              <= '0;
            y              <= '0;
            z              <= '0;
            w              <= '0;
            r0             <= '0;
            r1             <= '0;
            ndc_m_data     <= '0;
            ndc_m_div_zero <= 1'b0;
        end else begin
            if (vertex_fire) begin
                x             <= vertex_s_data[0*FIXED_WIDTH +: FIXED_WIDTH];
                y             <= vertex_s_data[1*FIXED_WIDTH +: FIXED_WIDTH];
                z             <= vertex_s_data[2*FIXED_WIDTH +: FIXED_WIDTH];
                w             <= vertex_s_data[3*FIXED_WIDTH +: FIXED_WIDTH];
                issue_idx     <= 2'd0;
                recv_cnt      <= 2'd0;
                dividend_sent <= 1'b0;
                divisor_sent  <= 1'b0;
                if (vertex_s_data[3*FIXED_WIDTH +: FIXED_WIDTH] == '0) begin
                    state          <= OUTPUT;
                    ndc_m_data     <= '0;
                    ndc_m_div_zero <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end
            if (state == RUN) begin
                dividend_sent <= issue_done ? 1'b0 : dividend_sent || dividend_fire;
                divisor_sent  <= issue_done ? 1'b0 : divisor_sent || divisor_fire;
                if (issue_done)
                    issue_idx <= issue_idx + 2'd1;
                if (quotient_fire) begin
                    recv_cnt <= recv_cnt + 2'd1;
                    if (recv_cnt == 2'd0)
                        r0 <= quotient_s_data;
                    if (recv_cnt == 2'd1)
                        r1 <= quotient_s_data;
                    if (recv_cnt == LAST - 2'd1) begin
                        state          <= OUTPUT;
                        ndc_m_data     <= {quotient_s_data, r1, r0};
                        ndc_m_div_zero <= 1'b0;
                    end
                end
            end
            if (ndc_m_valid && ndc_m_ready)
                state <= IDLE;
        end
    end
endmodule

// File: tb/tb_perspective_divider.sv
// tb_perspective_divider: drives perspective_divider against a latency-L divider model
// and checks every NDC vertex against a plain-arithmetic Q16.16 reference.
module tb_perspective_divider;
    localparam int L = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         vertex_s_valid = 1'b0;
    logic         vertex_s_ready;
    logic [127:0] vertex_s_data = '0;
    logic         dividend_m_valid;
    logic         dividend_m_ready = 1'b0;
    logic [31:0]  dividend_m_data;
    logic         divisor_m_valid;
    logic         divisor_m_ready = 1'b0;
    logic [31:0]  divisor_m_data;
    logic         quotient_s_valid = 1'b0;
    logic         quotient_s_ready;
    logic [31:0]  quotient_s_data = '0;
    logic         ndc_m_valid;
    logic         ndc_m_ready = 1'b0;
    logic [95:0]  ndc_m_data;
    logic         ndc_m_div_zero;
    logic         busy;

    perspective_divider dut (
        .clk(clk), .reset(reset),
        .vertex_s_valid(vertex_s_valid), .vertex_s_ready(vertex_s_ready), .vertex_s_data(vertex_s_data),
        .dividend_m_valid(dividend_m_valid), .dividend_m_ready(dividend_m_ready), .dividend_m_data(dividend_m_data),
        .divisor_m_valid(divisor_m_valid), .divisor_m_ready(divisor_m_ready), .divisor_m_data(divisor_m_data),
        .quotient_s_valid(quotient_s_valid), .quotient_s_ready(quotient_s_ready), .quotient_s_data(quotient_s_data),
        .ndc_m_valid(ndc_m_valid), .ndc_m_ready(ndc_m_ready), .ndc_m_data(ndc_m_data),
        .ndc_m_div_zero(ndc_m_div_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_dvd = 0, n_dvs = 0, n_q = 0, n_pair = 0, n_issue_valid = 0;
    bit rnd_ready = 0;
    bit q_rnd = 0;
    bit q_pop = 0;
    int dvs_hold = 0;

    typedef struct { logic [31:0] q; int t; } qent_t;
    logic [31:0] dvd_q[$];
    logic [31:0] dvs_q[$];
    qent_t out_q[$];

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        longint n, d;
        n = longint'($signed(a)) <<< 16;
        d = longint'($signed(b));
        return 32'(n / d);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Divider model: pairs dividend/divisor transfers in order, answers L edges later
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            dvd_q.delete();
            dvs_q.delete();
            out_q.delete();
        end else begin
            if (dividend_m_valid || divisor_m_valid) n_issue_valid++;
            if (dividend_m_valid && dividend_m_ready) begin dvd_q.push_back(dividend_m_data); n_dvd++; end
            if (divisor_m_valid && divisor_m_ready) begin dvs_q.push_back(divisor_m_data); n_dvs++; end
            if (quotient_s_valid && quotient_s_ready) begin void'(out_q.pop_front()); n_q++; q_pop = 1; end
            while (dvd_q.size() > 0 && dvs_q.size() > 0) begin
                out_q.push_back('{fdiv(dvd_q.pop_front(), dvs_q.pop_front()), cyc + L - 1});
                n_pair++;
            end
        end
    end

    always @(negedge clk) begin
        dividend_m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        divisor_m_ready = dvs_hold > 0 ? 1'b0 : rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dvs_hold > 0) dvs_hold--;
        if (out_q.size() == 0) quotient_s_valid = 1'b0;
        else begin
            if (!(quotient_s_valid && !q_pop))
                quotient_s_valid = out_q[0].t <= cyc && !(q_rnd && $urandom_range(0, 1) == 1);
            quotient_s_data = out_q[0].q;
        end
        q_pop = 0;
    end

    task automatic send(input logic [127:0] d, output int e0);
        int t = 0;
        vertex_s_data = d;
        vertex_s_valid = 1'b1;
        while (!vertex_s_ready && t < 200) begin @(negedge clk); t++; end
        check("accept_timeout", t < 200, 1);
        e0 = cyc + 1;
        @(negedge clk);
        vertex_s_valid = 1'b0;
        vertex_s_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_vertex(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                              input logic [31:0] w, input int hold, input bit rnd, input int exp_lat,
                              output logic [95:0] got);
        logic [95:0] exp_d, held;
        logic exp_z, hz;
        bit seen = 0, done = 0;
        int e0, t = 0;
        exp_z = w == 0;
        exp_d = exp_z ? 96'd0 : {fdiv(z, w), fdiv(y, w), fdiv(x, w)};
        held = '0;
        hz = 1'b0;
        ndc_m_ready = 1'b0;
        send({w, z, y, x}, e0);
        while (!done && t < 2000) begin
            ndc_m_ready = hold > 0 ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("vs_ready_busy", vertex_s_ready, 0);
            if (ndc_m_valid) begin
                if (!seen) begin
                    seen = 1;
                    held = ndc_m_data;
                    hz = ndc_m_div_zero;
                    if (exp_lat >= 0) check("latency", cyc + 1 - e0, exp_lat);
                end else check("ndc_hold", {ndc_m_div_zero, ndc_m_data}, {hz, held});
                if (hold > 0) hold--;
                done = ndc_m_ready;
            end
            @(negedge clk);
            t++;
        end
        check("ndc_timeout", done, 1);
        check("ndc_data", held, exp_d);
        check("div_zero", hz, exp_z);
        ndc_m_ready = 1'b0;
        check("back_to_idle", {ndc_m_valid, vertex_s_ready, busy}, 3'b010);
        got = held;
    endtask

    initial begin
        logic [95:0] got;
        int b_dvd, b_dvs, b_q, b_iv, base, t, e0;
        logic [31:0] w;
        repeat (3) @(negedge clk);
        check("rst_vs_ready", vertex_s_ready, 0);
        check("rst_valids", {dividend_m_valid, divisor_m_valid, quotient_s_ready, ndc_m_valid}, 0);
        check("rst_ndc", {ndc_m_div_zero, ndc_m_data}, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", {vertex_s_ready, busy}, 2'b10);

        run_vertex(32'h00040000, 32'hFFFE0000, 32'h00010000, 32'h00020000, 0, 0, L + 4, got);
        check("basic_const", got, {32'h00008000, 32'hFFFF0000, 32'h00020000});

        b_iv = n_issue_valid;
        run_vertex(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'h0, 0, 0, 1, got);
        check("zero_w_no_issue", n_issue_valid - b_iv, 0);

        b_dvd = n_dvd; b_dvs = n_dvs;
        dvs_hold = 6;
        run_vertex(32'h00090000, 32'hFFFA0000, 32'h00030000, 32'h00030000, 0, 0, -1, got);
        check("skew_dvd_count", n_dvd - b_dvd, 3);
        check("skew_dvs_count", n_dvs - b_dvs, 3);

        q_rnd = 1;
        run_vertex(32'hFFF80000, 32'h00050000, 32'h00018000, 32'hFFFC0000, 10, 0, -1, got);
        q_rnd = 0;

        base = n_pair;
        send({32'h00020000, 32'h00060000, 32'h00040000, 32'h00020000}, e0);
        t = 0;
        while (n_pair - base < 2 && t < 100) begin @(negedge clk); t++; end
        check("mid_issue_timeout", t < 100, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valids", {dividend_m_valid, divisor_m_valid, quotient_s_ready, ndc_m_valid}, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", vertex_s_ready, 1);
        run_vertex(32'h00030000, $urandom, $urandom, 32'h00030000, 0, 0, L + 4, got);
        check("after_rst_x", got[31:0], 32'h00010000);

        b_dvd = n_dvd; b_dvs = n_dvs; b_q = n_q;
        rnd_ready = 1;
        q_rnd = 1;
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            if (w == 0) w = 32'h00010000;
            run_vertex($urandom, $urandom, $urandom, w, $urandom_range(0, 3), 1, -1, got);
        end
        rnd_ready = 0;
        q_rnd = 0;
        check("stream_dvd_count", n_dvd - b_dvd, 60);
        check("stream_dvs_count", n_dvs - b_dvs, 60);
        check("stream_q_count", n_q - b_q, 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
